// File: rtl/conv_sequencer.sv
// Sequencer computing the 1-D linear convolution z = x * y from two read-only sample memories.
// Define CONV_SEQ_SATURATE_EN to clamp each output word to all-ones on overflow instead of wrapping.
module conv_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic                 start,
  input  logic [4:0]           size_x,
  input  logic [4:0]           size_y,
  output logic [ADDRWIDTH-1:0] addr_x,
  output logic [ADDRWIDTH-1:0] addr_y,
  input  logic [DATAWIDTH-1:0] data_x,
  input  logic [DATAWIDTH-1:0] data_y,
  output logic                 wr_z,
  output logic [ADDRWIDTH-1:0] addr_z,
  output logic [DATAWIDTH-1:0] data_z,
  output logic                 busy,
  output logic                 done
);

  // state | meaning
  // IDLE  | waiting for start
  // SETUP | compute term range for output k, clear accumulator
  // FETCH | x/y addresses presented to the memories
  // ACC   | read data valid, accumulate one product
  // WRITE | z[k] strobed out
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDRWIDTH-1:0] ONE = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] TWO = ADDRWIDTH'(2);

  logic [2:0]           state_q, state_d;
  logic [4:0]           sx_q, sx_d, sy_q, sy_d;
  logic [ADDRWIDTH-1:0] k_q, k_d, i_q, i_d, i_end_q, i_end_d;
  logic [ADDRWIDTH-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d, addr_z_q, addr_z_d;
  logic [DATAWIDTH-1:0] acc_q, acc_d, data_z_q, data_z_d;
  logic [DATAWIDTH-1:0] acc_next;

  logic [ADDRWIDTH-1:0] sx_w, sy_w, k_plus1, i_start, i_last, n_last;

  assign sx_w    = ADDRWIDTH'(sx_q);
  assign sy_w    = ADDRWIDTH'(sy_q);
  assign k_plus1 = k_q + ONE;
  assign i_start = (k_plus1 > sy_w) ? (k_plus1 - sy_w) : '0;
  assign i_last  = (k_q < (sx_w - ONE)) ? k_q : (sx_w - ONE);
  assign n_last  = sx_w + sy_w - TWO;

`ifdef CONV_SEQ_SATURATE_EN
  logic [2*DATAWIDTH-1:0] prod_full;
  logic [DATAWIDTH:0]     sum;

  // Once clamped, acc stays all-ones: any further nonzero product overflows again.
  always_comb begin
    prod_full = (2*DATAWIDTH)'(data_x) * (2*DATAWIDTH)'(data_y);
    sum       = {1'b0, acc_q} + {1'b0, prod_full[DATAWIDTH-1:0]};
    acc_next  = sum[DATAWIDTH-1:0];
    if ((|prod_full[2*DATAWIDTH-1:DATAWIDTH]) || sum[DATAWIDTH]) acc_next = '1;
  end
`else
  logic [DATAWIDTH-1:0] prod;

  always_comb begin
    prod     = data_x * data_y;
    acc_next = acc_q + prod;
  end
`endif

  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    k_d      = k_q;
    i_d      = i_q;
    i_end_d  = i_end_q;
    acc_d    = acc_q;
    addr_x_d = addr_x_q;
    addr_y_d = addr_y_q;
    addr_z_d = addr_z_q;
    data_z_d = data_z_q;
    if (en_s) begin
      case (state_q)
        S_IDLE: if (start) begin
          sx_d    = size_x;
          sy_d    = size_y;
          k_d     = '0;
          state_d = (size_x == 5'd0 || size_y == 5'd0) ? S_DONE : S_SETUP;
        end
        S_SETUP: begin
          i_d      = i_start;
          i_end_d  = i_last;
          acc_d    = '0;
          addr_x_d = i_start;
          addr_y_d = k_q - i_start;
          state_d  = S_FETCH;
        end
        S_FETCH: state_d = S_ACC;
        S_ACC: begin
          acc_d = acc_next;
          if (i_q == i_end_q) begin
            addr_z_d = k_q;
            data_z_d = acc_next;
            state_d  = S_WRITE;
          end else begin
            i_d      = i_q + ONE;
            addr_x_d = i_q + ONE;
            addr_y_d = k_q - (i_q + ONE);
            state_d  = S_FETCH;
          end
        end
        S_WRITE: begin
          if (k_q == n_last) state_d = S_DONE;
          else begin
            k_d     = k_plus1;
            state_d = S_SETUP;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q  <= S_IDLE;
      sx_q     <= '0;
      sy_q     <= '0;
      k_q      <= '0;
      i_q      <= '0;
      i_end_q  <= '0;
      acc_q    <= '0;
      addr_x_q <= '0;
      addr_y_q <= '0;
      addr_z_q <= '0;
      data_z_q <= '0;
    end else begin
      state_q  <= state_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      k_q      <= k_d;
      i_q      <= i_d;
      i_end_q  <= i_end_d;
      acc_q    <= acc_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      addr_z_q <= addr_z_d;
      data_z_q <= data_z_d;
    end
  end

  assign addr_x = addr_x_q;
  assign addr_y = addr_y_q;
  assign addr_z = addr_z_q;
  assign data_z = data_z_q;
  assign wr_z   = en_s && (state_q == S_WRITE);
  assign done   = en_s && (state_q == S_DONE);
  assign busy   = (state_q == S_SETUP) || (state_q == S_FETCH) ||
                  (state_q == S_ACC)   || (state_q == S_WRITE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized bench for conv_sequencer: behavioural convolution model, write scoreboard, latency and control checks.
module tb_conv_sequencer;
  localparam int W = 32;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_a, en_s, start;
  logic [4:0]   size_x, size_y;
  logic [5:0]   addr_x, addr_y, addr_z;
  logic [W-1:0] data_x, data_y, data_z;
  logic         wr_z, busy, done;

  logic [W-1:0] mem_x [64];
  logic [W-1:0] mem_y [64];

  logic [W-1:0] exp_q[$];
  logic [5:0]   wr_addr_q[$];
  logic [W-1:0] wr_data_q[$];
  bit           busy_seen;

  int checks = 0;
  int errors = 0;

  conv_sequencer #(.DATAWIDTH(W), .ADDRWIDTH(6)) dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start),
    .size_x(size_x), .size_y(size_y),
    .addr_x(addr_x), .addr_y(addr_y), .data_x(data_x), .data_y(data_y),
    .wr_z(wr_z), .addr_z(addr_z), .data_z(data_z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data follows the address by one cycle.
  always @(posedge clk) begin
    data_x <= mem_x[addr_x];
    data_y <= mem_y[addr_y];
  end

  always @(negedge clk) begin
    if (wr_z) begin
      wr_addr_q.push_back(addr_z);
      wr_data_q.push_back(data_z);
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Direct evaluation of z[k] = sum x[i]*y[k-i] over all valid (i, k-i) pairs.
  function automatic void build_expected(input int sx, input int sy);
    exp_q.delete();
    if (sx == 0 || sy == 0) return;
    for (int k = 0; k <= sx + sy - 2; k++) begin
      longint unsigned acc = 0;
      for (int i = 0; i < sx; i++) begin
        int j = k - i;
        longint unsigned p;
        if (j < 0 || j >= sy) continue;
        p = {32'h0, mem_x[i]} * {32'h0, mem_y[j]};
`ifdef CONV_SEQ_SATURATE_EN
        if (p > MAXV || acc + p > MAXV) acc = MAXV;
        else acc = acc + p;
`else
        acc = (acc + (p & MAXV)) & MAXV;
`endif
      end
      exp_q.push_back(acc[31:0]);
    end
  endfunction

  task automatic fill_rand();
    for (int n = 0; n < 64; n++) begin
      mem_x[n] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
      mem_y[n] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
    end
  endtask

  task automatic run_conv(input int sx, input int sy, input bit rnd_en, input bit inject, input string tag);
    int  lat = 0;
    int  iter = 0;
    int  exp_lat;
    bit  got_done = 0;
    build_expected(sx, sy);
    exp_lat = (sx == 0 || sy == 0) ? 0 : 2 * (sx + sy - 1) + 2 * sx * sy;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    busy_seen = 1'b0;
    en_s = 1'b1; start = 1'b1; size_x = 5'(sx); size_y = 5'(sy);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (!got_done && iter < 8000) begin
      if (done) begin
        got_done = 1;
      end else begin
        iter++;
        size_x = 5'($urandom);
        size_y = 5'($urandom);
        start  = inject && (iter == 3 || iter == 9);
        if (inject && iter == 3) size_x = 5'd9;
        en_s   = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk);
        if (en_s) lat++;
        @(negedge clk);
      end
    end
    if (!got_done) check({tag, "_timeout"}, done, 1);
    start = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_seen"}, busy_seen, (sx != 0 && sy != 0));
    en_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_wr_count"}, wr_addr_q.size(), exp_q.size());
    for (int n = 0; n < exp_q.size() && n < wr_addr_q.size(); n++) begin
      check($sformatf("%s_addr%0d", tag, n), wr_addr_q[n], n);
      check($sformatf("%s_data%0d", tag, n), wr_data_q[n], exp_q[n]);
    end
  endtask

  initial begin
    int wait_cnt;
    rst_a = 1'b0; en_s = 1'b0; start = 1'b0; size_x = '0; size_y = '0;
    for (int n = 0; n < 64; n++) begin mem_x[n] = '0; mem_y[n] = '0; end
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_z", wr_z, 0);
    check("rst_addr_x", addr_x, 0);
    check("rst_data_z", data_z, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;

    // All-ones sequences give the trapezoid 1..5..1.
    for (int n = 0; n < 64; n++) begin mem_x[n] = 1; mem_y[n] = 1; end
    run_conv(5, 10, 0, 0, "ones");
    check("ones_z4", wr_data_q.size() > 4 ? wr_data_q[4] : 0, 5);

    mem_x[0] = 7; mem_y[0] = 6;
    run_conv(1, 1, 0, 0, "single");
    check("single_z0", wr_data_q.size() > 0 ? wr_data_q[0] : 0, 42);

    // Zero size: done right after the sampling edge, i.e. one edge after start is raised.
    run_conv(0, 10, 0, 0, "zero_x");
    run_conv(7, 0, 1, 0, "zero_y");

    fill_rand();
    run_conv(3, 2, 0, 1, "inject");

    mem_x[0] = 32'hFFFF_FFFF; mem_y[0] = 2;
    run_conv(1, 1, 0, 0, "ovf");
`ifdef CONV_SEQ_SATURATE_EN
    check("ovf_word", wr_data_q.size() > 0 ? wr_data_q[0] : 0, 32'hFFFF_FFFF);
`else
    check("ovf_word", wr_data_q.size() > 0 ? wr_data_q[0] : 0, 32'hFFFF_FFFE);
`endif

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      run_conv($urandom_range(0, 12), $urandom_range(0, 12), r[0], r == 5, $sformatf("rnd%0d", r));
    end
    fill_rand();
    run_conv(31, 31, 1, 0, "max");

    // Abort during the write of z[3].
    fill_rand();
    @(negedge clk);
    en_s = 1'b1; start = 1'b1; size_x = 5'd5; size_y = 5'd5;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!(wr_z && addr_z == 6'd3) && wait_cnt < 500) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("abort_reached_k3", addr_z, 3);
    rst_a = 1'b0;
    #1;
    check("abort_wr_z", wr_z, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr_x", addr_x, 0);
    check("abort_addr_y", addr_y, 0);
    check("abort_addr_z", addr_z, 0);
    check("abort_data_z", data_z, 0);
    @(negedge clk);
    rst_a = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    repeat (10) @(negedge clk);
    check("abort_no_wr", wr_addr_q.size(), 0);
    run_conv(5, 5, 0, 0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter DATAWIDTH, 32: width of sample, accumulator and result words.
REQ-002 Parameter ADDRWIDTH, 6: memory address width (64 entries).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_a  in  1  reset, asynchronous, active-low.
REQ-005 en_s  in  1  synchronous enable; 0 freezes all state.
REQ-006 start  in  1  one-cycle start request.
REQ-007 size_x  in  5  number of X samples (0..31).
REQ-008 size_y  in  5  number of Y samples (0..31).
REQ-009 addr_x / addr_y  out  ADDRWIDTH  read addresses for X and Y memories.
REQ-010 data_x / data_y  in  DATAWIDTH  read data, valid one cycle after address.
REQ-011 wr_z  out  1  result-memory write strobe.
REQ-012 addr_z  out  ADDRWIDTH  result write address.
REQ-013 data_z  out  DATAWIDTH  result write data.
REQ-014 busy  out  1  high while a convolution is in progress.
REQ-015 done  out  1  one-cycle completion pulse, feeds the core's DONE interrupt bit.

Function
REQ-016 Computes z[k] = sum x[i]*y[k-i], k = 0..N-1, N = sx+sy-1, i from max(0,k-sy+1) to min(k,sx-1); all values unsigned.
REQ-017 Product truncated to DATAWIDTH bits; accumulation modulo 2^DATAWIDTH (unless REQ-031).
REQ-018 States: IDLE, SETUP, FETCH, ACC, WRITE, DONE.
REQ-019 IDLE: busy=0; on start=1 with en_s=1, latch size_x/size_y into sx/sy; go SETUP, or DONE if sx=0 or sy=0.
REQ-020 SETUP: i=max(0,k-sy+1), i_end=min(k,sx-1), acc=0; -> FETCH.
REQ-021 FETCH: drive addr_x=i, addr_y=k-i; -> ACC.
REQ-022 ACC: acc += data_x*data_y; if i=i_end -> WRITE else i+1 -> FETCH.
REQ-023 WRITE: wr_z=1 one cycle, addr_z=k, data_z=acc; if k=N-1 -> DONE else k+1 -> SETUP.
REQ-024 DONE: done=1 one cycle; -> IDLE.
REQ-025 Latency: done high 2N+2*sx*sy edges after the edge sampling start; zero-size: 1 edge, no wr_z.
REQ-026 start while busy ignored; size_x/size_y changes while busy ignored.
REQ-027 en_s=0: state, counters, acc held; wr_z and done forced 0; resume exactly where frozen.
REQ-028 addr_x, addr_y, addr_z, data_z hold last value outside their active states.

Reset
REQ-029 rst_a=0 immediately forces IDLE; busy, done, wr_z, addr_x, addr_y, addr_z, data_z, acc, counters = 0.
REQ-030 Reset mid-operation aborts; no further wr_z; next start runs a full fresh convolution.

Configuration
REQ-031 Macro CONV_SEQ_SATURATE_EN defined: product >= 2^DATAWIDTH and any accumulate overflow clamp to all-ones, sticky per output word; undefined: plain wrap-around per REQ-017.

Verification
REQ-032 sx=5, sy=10, all x=1, y=1 -> z[0..13] = 1,2,3,4,5,5,5,5,5,5,4,3,2,1 at addr 0..13; done 128 edges after start.
REQ-033 sx=1, sy=1, x0=7, y0=6 -> single wr_z, addr_z=0, data_z=42; done 4 edges after start.
REQ-034 sx=0, sy=10 -> no wr_z, busy never high, done 1 edge after start.
REQ-035 sx=3, sy=2 running, extra start plus size_x=9 mid-run -> ignored; z matches sx=3, sy=2 reference.
REQ-036 rst_a low during WRITE of k=3 -> all outputs 0 at once, no more wr_z; new start completes correctly.
REQ-037 sx=sy=1, x0=FFFFFFFF, y0=2 -> data_z=FFFFFFFF with CONV_SEQ_SATURATE_EN, FFFFFFFE without.
